// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB writeback bus plus ID-stage read ports of the register file.
//   master : pipeline side, drives writeback request, flags and read addresses
//   slave  : register file side, returns read data, forwarded data, flags, counter
// AW must equal $clog2(NREG) of the attached wb_regfile.
interface wb_regfile_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
);
    // MEM/WB writeback request
    logic          en_wb;
    logic          regwrite;
    logic          from_main_mem;
    logic [AW-1:0] regwrite_adr;
    logic [DW-1:0] regwrite_dat_wb;
    logic [DW-1:0] main_mem_dat_wb;
    logic          flag_we_wb;
    logic          S_wb;
    logic          C_wb;
    logic          Z_wb;
    logic          V_wb;

    // ID-stage read ports
    logic [AW-1:0] rd_adr_a;
    logic [AW-1:0] rd_adr_b;
    logic [DW-1:0] rd_dat_a;
    logic [DW-1:0] rd_dat_b;

    // Forwarding / status
    logic [DW-1:0] wb_dat;
    logic          wb_valid;
    logic          S;
    logic          C;
    logic          Z;
    logic          V;
    logic [15:0]   retire_cnt;

    modport master (
        output en_wb, regwrite, from_main_mem, regwrite_adr,
               regwrite_dat_wb, main_mem_dat_wb,
               flag_we_wb, S_wb, C_wb, Z_wb, V_wb,
               rd_adr_a, rd_adr_b,
        input  rd_dat_a, rd_dat_b, wb_dat, wb_valid,
               S, C, Z, V, retire_cnt
    );

    modport slave (
        input  en_wb, regwrite, from_main_mem, regwrite_adr,
               regwrite_dat_wb, main_mem_dat_wb,
               flag_we_wb, S_wb, C_wb, Z_wb, V_wb,
               rd_adr_a, rd_adr_b,
        output rd_dat_a, rd_dat_b, wb_dat, wb_valid,
               S, C, Z, V, retire_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage. Selects ALU or load data, commits it to an
// NREG x DW register file, commits SZCV flags and counts retired writes.
// Two combinational read ports with same-cycle write-through bypass.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high; clears registers, flags and counter
//   bus   : wb_regfile_if slave modport (writeback request, read ports, status)
module wb_regfile #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8
) (
    input  logic        clk,
    input  logic        reset,
    wb_regfile_if.slave bus
);

    localparam int unsigned AW     = $clog2(NREG);
    localparam int unsigned NFLAG  = 4;
    localparam int unsigned CNT_W  = 16;

    logic [DW-1:0]    regs_q [NREG];
    logic [DW-1:0]    regs_d [NREG];
    logic [NFLAG-1:0] flags_q;          // {S, C, Z, V}
    logic [NFLAG-1:0] flags_d;
    logic [CNT_W-1:0] retire_cnt_q;
    logic [CNT_W-1:0] retire_cnt_d;

    logic             commit_c;
    logic             flag_commit_c;
    logic [DW-1:0]    wb_dat_c;
    logic             bypass_a_c;
    logic             bypass_b_c;
    logic [AW-1:0]    wr_adr_c;

    // Writeback data select and commit qualifiers; a stall suppresses everything.
    always_comb begin
        wb_dat_c      = bus.from_main_mem ? bus.main_mem_dat_wb : bus.regwrite_dat_wb;
        commit_c      = bus.en_wb & bus.regwrite;
        flag_commit_c = bus.en_wb & bus.flag_we_wb;
        wr_adr_c      = bus.regwrite_adr;
    end

    // Per-port write-through bypass so ID sees the value being written this cycle.
    always_comb begin
        bypass_a_c = commit_c && (bus.rd_adr_a == wr_adr_c);
        bypass_b_c = commit_c && (bus.rd_adr_b == wr_adr_c);
    end

    // Next-state for register array, flags and retire counter.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        flags_d      = flags_q;
        retire_cnt_d = retire_cnt_q;

        if (commit_c) begin
            regs_d[wr_adr_c] = wb_dat_c;
            retire_cnt_d     = retire_cnt_q + CNT_W'(1);   // wraps silently
        end

        if (flag_commit_c) begin
            flags_d = {bus.S_wb, bus.C_wb, bus.Z_wb, bus.V_wb};
        end
    end

    // State registers; reset overrides any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            flags_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flags_q      <= flags_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Combinational read ports and forwarding outputs.
    assign bus.rd_dat_a   = bypass_a_c ? wb_dat_c : regs_q[bus.rd_adr_a];
    assign bus.rd_dat_b   = bypass_b_c ? wb_dat_c : regs_q[bus.rd_adr_b];
    assign bus.wb_dat     = wb_dat_c;
    assign bus.wb_valid   = commit_c;

    // Flags are architectural state only; no bypass.
    assign bus.S          = flags_q[3];
    assign bus.C          = flags_q[2];
    assign bus.Z          = flags_q[1];
    assign bus.V          = flags_q[0];
    assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed scenarios plus randomized traffic, checked by
// a scoreboard fed from a behavioural model and drained by a negedge monitor.
module tb_wb_regfile;

    logic clk;
    logic reset;

    wb_regfile_if #(.DW(16), .AW(3)) bus ();

    wb_regfile #(.DW(16), .NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd_a;
        logic [15:0] rd_b;
        logic [15:0] wd;
        logic        wv;
        logic [3:0]  fl;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp;
    int n_bad;

    // Behavioural model of architectural state
    logic [15:0] m_reg [8];
    logic [3:0]  m_flags;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd_dat_a",   32'(bus.rd_dat_a),   32'(e.rd_a));
            check("rd_dat_b",   32'(bus.rd_dat_b),   32'(e.rd_b));
            check("wb_dat",     32'(bus.wb_dat),     32'(e.wd));
            check("wb_valid",   32'(bus.wb_valid),   32'(e.wv));
            check("flags_SCZV", 32'({bus.S, bus.C, bus.Z, bus.V}), 32'(e.fl));
            check("retire_cnt", 32'(bus.retire_cnt), 32'(e.cnt));
        end
    end

    // One bus cycle: drive, predict this cycle's outputs, then advance the model.
    task automatic cyc(input bit rst, input bit en, input bit rw, input bit fm,
                       input logic [2:0] adr, input logic [15:0] alu, input logic [15:0] mem,
                       input bit fwe, input logic [3:0] fl,
                       input logic [2:0] ra, input logic [2:0] rb);
        exp_t        e;
        logic [15:0] wdat;
        bit          wr;
        @(posedge clk);
        #1;
        reset               = rst;
        bus.en_wb           = en;
        bus.regwrite        = rw;
        bus.from_main_mem   = fm;
        bus.regwrite_adr    = adr;
        bus.regwrite_dat_wb = alu;
        bus.main_mem_dat_wb = mem;
        bus.flag_we_wb      = fwe;
        {bus.S_wb, bus.C_wb, bus.Z_wb, bus.V_wb} = fl;
        bus.rd_adr_a        = ra;
        bus.rd_adr_b        = rb;

        wdat   = fm ? mem : alu;
        wr     = en && rw;
        e.wd   = wdat;
        e.wv   = wr;
        e.rd_a = (wr && ra == adr) ? wdat : m_reg[ra];
        e.rd_b = (wr && rb == adr) ? wdat : m_reg[rb];
        e.fl   = m_flags;
        e.cnt  = m_cnt;
        exp_q.push_back(e);

        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 16'h0000;
            m_flags = 4'h0;
            m_cnt   = 16'h0000;
        end else begin
            if (wr) begin
                m_reg[adr] = wdat;
                m_cnt      = m_cnt + 16'h0001;
            end
            if (en && fwe) m_flags = fl;
        end
    endtask

    task automatic rd(input logic [2:0] ra, input logic [2:0] rb);
        cyc(0, 1, 0, 0, 3'd0, 16'h0, 16'h0, 0, 4'h0, ra, rb);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        foreach (m_reg[i]) m_reg[i] = 16'h0000;
        m_flags = 4'h0;
        m_cnt   = 16'h0000;

        reset               = 1'b1;
        bus.en_wb           = 1'b0;
        bus.regwrite        = 1'b0;
        bus.from_main_mem   = 1'b0;
        bus.regwrite_adr    = 3'd0;
        bus.regwrite_dat_wb = 16'h0;
        bus.main_mem_dat_wb = 16'h0;
        bus.flag_we_wb      = 1'b0;
        {bus.S_wb, bus.C_wb, bus.Z_wb, bus.V_wb} = 4'h0;
        bus.rd_adr_a        = 3'd0;
        bus.rd_adr_b        = 3'd0;
        @(posedge clk);

        // Reset state on every address, both ports
        cyc(1, 0, 0, 0, 3'd0, 16'h0, 16'h0, 0, 4'h0, 3'd0, 3'd7);
        for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i));

        // ALU write with bypass, then visible through the array
        cyc(0, 1, 1, 0, 3'd3, 16'h1234, 16'hBEEF, 0, 4'h0, 3'd3, 3'd0);
        rd(3'd3, 3'd3);

        // Stalled load write: no bypass, no commit; then released
        cyc(0, 0, 1, 1, 3'd5, 16'h1111, 16'hA5A5, 0, 4'h0, 3'd5, 3'd5);
        rd(3'd5, 3'd3);
        cyc(0, 1, 1, 1, 3'd5, 16'h1111, 16'hA5A5, 0, 4'h0, 3'd5, 3'd1);
        rd(3'd5, 3'd5);

        // Flag commit then hold
        cyc(0, 1, 0, 0, 3'd0, 16'h0, 16'h0, 1, 4'b1011, 3'd0, 3'd0);
        cyc(0, 1, 0, 0, 3'd0, 16'h0, 16'h0, 0, 4'b0000, 3'd0, 3'd0);
        rd(3'd0, 3'd0);

        // Stalled flag update is ignored; flags + reg write same cycle both commit
        cyc(0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 1, 4'b0100, 3'd0, 3'd0);
        cyc(0, 1, 1, 0, 3'd0, 16'h00AA, 16'h0, 1, 4'b0110, 3'd0, 3'd0);
        rd(3'd0, 3'd0);

        // Reset beats a simultaneous write; next cycle the write lands
        cyc(1, 1, 1, 0, 3'd2, 16'hFFFF, 16'h0, 1, 4'hF, 3'd2, 3'd3);
        cyc(0, 1, 1, 0, 3'd2, 16'hFFFF, 16'h0, 0, 4'h0, 3'd2, 3'd3);
        rd(3'd2, 3'd3);

        // Drive the counter to 0xFFFF, then one more commit wraps it
        while (m_cnt != 16'hFFFF) begin
            cyc(0, 1, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                16'($urandom), 16'($urandom), 0, 4'h0,
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        cyc(0, 1, 1, 0, 3'd6, 16'h0F0F, 16'h0, 0, 4'h0, 3'd6, 3'd7);
        rd(3'd6, 3'd7);

        // Randomized mixed traffic with occasional stalls, flushes and resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)),
                16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback data (ALU result or main-memory load data) and commits it to the 8x16 general register file.
- Commits SZCV condition flags into the flag register.
- Serves two combinational read ports to the ID stage, with same-cycle write-through bypass.
- Keeps a 16-bit writeback-retire counter for debug/performance readout.

Parameters:
- DW, 16, datapath / register width
- NREG, 8, number of general registers (address width = 3)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- en_wb  in  1  writeback enable; 0 = stall, no architectural state changes
- regwrite  in  1  register write request from MEM/WB
- from_main_mem  in  1  1 = write main_mem_dat_wb, 0 = write regwrite_dat_wb
- regwrite_adr  in  3  destination register
- regwrite_dat_wb  in  DW  ALU/shift result
- main_mem_dat_wb  in  DW  load data
- flag_we_wb  in  1  flag register update request
- S_wb, C_wb, Z_wb, V_wb  in  1 each  condition flags from MEM/WB
- rd_adr_a, rd_adr_b  in  3 each  ID-stage read addresses
- rd_dat_a, rd_dat_b  out  DW each  read data (combinational)
- wb_dat  out  DW  selected writeback data (combinational, for forwarding)
- wb_valid  out  1  regwrite & en_wb (combinational)
- S, C, Z, V  out  1 each  architectural flag register
- retire_cnt  out  16  count of committed register writes

Behaviour:
- Clocking: clk only; reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Reset: all NREG registers = 0, S=C=Z=V=0, retire_cnt = 0. Reset wins over any simultaneous write.
- Data select: wb_dat = from_main_mem ? main_mem_dat_wb : regwrite_dat_wb. Pure mux; no latency.
- Register write: at the edge, if en_wb & regwrite, reg[regwrite_adr] <= wb_dat. Otherwise all registers hold.
- Register 0 is an ordinary register, not hardwired to zero.
- Read ports are combinational:
  - rd_dat_x = bypass ? wb_dat : reg[rd_adr_x]
  - bypass = en_wb & regwrite & (rd_adr_x == regwrite_adr)
  - Both ports bypass independently. Both ports may address the same register or the write target simultaneously.
- Flags: at the edge, if en_wb & flag_we_wb, {S,C,Z,V} <= {S_wb,C_wb,Z_wb,V_wb}. Otherwise hold.
  - Flag outputs are registered only; there is no flag bypass.
  - A flag update and a register write in the same cycle are both committed.
- retire_cnt: increments by 1 at each edge with en_wb & regwrite. Wraps 0xFFFF -> 0x0000 silently. Holds when en_wb=0.
- Stall (en_wb=0): no register, flag or counter change, and no bypass; wb_valid=0.
- MEM/WB flush arrives as regwrite=0 / flag_we_wb=0 and causes no state change.
- Reset mid-stream: a write presented in the reset cycle is discarded. The first post-reset edge accepts normal writes.
- Latency: a write committed at edge N is visible through the array at N+1, and via bypass within cycle N.

Test Plan:
- Reset, then read all 8 addresses on both ports -> all 0; S=C=Z=V=0; retire_cnt=0.
- regwrite=1, adr=3, from_main_mem=0, regwrite_dat_wb=0x1234, main_mem_dat_wb=0xBEEF, rd_adr_a=3 -> rd_dat_a=0x1234 in the same cycle (bypass). After the edge, reg3=0x1234 and retire_cnt=1.
- from_main_mem=1, adr=5, main_mem_dat_wb=0xA5A5, en_wb=0 -> no bypass, reg5 stays 0, retire_cnt unchanged. Raise en_wb=1 -> reg5=0xA5A5.
- flag_we_wb=1 with S,C,Z,V=1,0,1,1 -> flags 1011 after the edge. Next cycle flag_we_wb=0 with inputs 0000 -> flags hold 1011.
- Preload retire_cnt via 65535 writes, then one more write -> retire_cnt wraps to 0x0000.
- Assert reset together with regwrite=1, adr=2, data=0xFFFF -> reg2=0, retire_cnt=0. Next cycle the same write -> reg2=0xFFFF.
